// File: rtl/ccastles_pkg.sv
// Shared types and widths for the Crystal Castles trackball synthesiser.
// Counter and mouse-delta widths plus the per-axis motion states.
package ccastles_pkg;

  localparam int TB_W      = 8;
  localparam int MOUSE_W   = 9;
  localparam int MOUSE_SAT = 127;

  typedef enum logic [1:0] {
    IDLE,
    ACCEL,
    CRUISE
  } axis_state_t;

endpackage

// File: rtl/ccastles_tb_axis.sv
// One trackball axis: tick-driven speed-ramp FSM and saturated mouse delta into a wrapping counter.
// pos updates on the edge closing a tick or mouse-event cycle; no backpressure, inputs are sampled as levels.
module ccastles_tb_axis
  import ccastles_pkg::*;
#(
  parameter int MAX_SPEED   = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               dir_pos,
  input  logic               dir_neg,
  input  logic               mouse_vld,
  input  logic [MOUSE_W-1:0] mouse_dat,
  input  logic               mouse_inv,
  output logic [TB_W-1:0]    pos,
  output logic               active
);

  localparam int STEP_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ACCEL_TICKS - 1);
  localparam logic [3:0] SPEED_MAX = 4'(MAX_SPEED);
  localparam logic signed [MOUSE_W-1:0] SAT_HI = MOUSE_W'(MOUSE_SAT);
  localparam logic signed [MOUSE_W-1:0] SAT_LO = -SAT_HI;

  axis_state_t       state;
  axis_state_t       run_state;
  logic [3:0]        speed;
  logic [3:0]        speed_new;
  logic [STEP_W-1:0] step_cnt;
  logic              last_neg;
  logic              dir_any;
  logic              rev;
  logic              restart;
  logic              ramp_up;
  logic [TB_W-1:0]   joy_mag;
  logic [TB_W-1:0]   joy_d;
  logic [TB_W-1:0]   mouse_sat;
  logic [TB_W-1:0]   mouse_d;

  assign dir_any = dir_pos | dir_neg;
  assign rev     = (dir_pos & last_neg) | (dir_neg & ~last_neg);
  assign restart = (state == IDLE) | rev;
  assign ramp_up = (state == ACCEL) && (step_cnt == STEP_LAST);

  // Speed that applies to this tick; the delta uses it, so a fresh press moves by 1 at once.
  always_comb begin
    speed_new = speed;
    if (!dir_any) begin
      speed_new = '0;
    end else if (restart) begin
      speed_new = 4'd1;
    end else if (ramp_up) begin
      speed_new = speed + 4'd1;
    end
  end

  always_comb begin
    run_state = (speed_new >= SPEED_MAX) ? CRUISE : ACCEL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      speed    <= '0;
      step_cnt <= '0;
      last_neg <= 1'b0;
      active   <= 1'b0;
    end else if (tick) begin
      speed <= speed_new;
      if (!dir_any) begin
        state    <= IDLE;
        step_cnt <= '0;
        active   <= 1'b0;
      end else begin
        state  <= run_state;
        active <= 1'b1;
        if (restart) begin
          last_neg <= dir_neg;
        end
        if (restart || ramp_up || (state == CRUISE)) begin
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end
    end
  end

  always_comb begin
    if ($signed(mouse_dat) > SAT_HI) begin
      mouse_sat = TB_W'(MOUSE_SAT);
    end else if ($signed(mouse_dat) < SAT_LO) begin
      mouse_sat = -TB_W'(MOUSE_SAT);
    end else begin
      mouse_sat = mouse_dat[TB_W-1:0];
    end
  end

  // Inversion happens after saturation so -256 still maps cleanly to +127.
  assign mouse_d = !mouse_vld ? '0 : (mouse_inv ? -mouse_sat : mouse_sat);
  assign joy_mag = TB_W'(speed_new);
  assign joy_d   = !tick ? '0 : (dir_neg ? -joy_mag : joy_mag);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= '0;
    end else begin
      pos <= pos + joy_d + mouse_d;
    end
  end

endmodule

// File: rtl/ccastles_trackball.sv
// Trackball counters for the ccastles core from MiSTer joystick directions and PS/2 mouse deltas.
// Counters change one edge after a motion tick or mouse strobe toggle; no backpressure, mouse packets are never dropped.
module ccastles_trackball
  import ccastles_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int MAX_SPEED   = 8,
  parameter int ACCEL_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               joy_right,
  input  logic               joy_left,
  input  logic               joy_down,
  input  logic               joy_up,
  input  logic [MOUSE_W-1:0] mouse_dx,
  input  logic [MOUSE_W-1:0] mouse_dy,
  input  logic               mouse_strobe,
  input  logic               flip,
  output logic [TB_W-1:0]    tbx,
  output logic [TB_W-1:0]    tby,
  output logic               moving
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             strobe_q;
  logic             strobe_armed;
  logic             mouse_vld;
  logic             x_pos, x_neg, y_pos, y_neg;
  logic             x_active, y_active;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // The first clock only captures the strobe level, so a high strobe at reset release is not an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q     <= 1'b0;
      strobe_armed <= 1'b0;
    end else begin
      strobe_q     <= mouse_strobe;
      strobe_armed <= 1'b1;
    end
  end

  assign mouse_vld = strobe_armed & (mouse_strobe ^ strobe_q);

  // Opposing inputs cancel; flip swaps the sense of both axes.
  assign x_pos = flip ? (joy_left & ~joy_right) : (joy_right & ~joy_left);
  assign x_neg = flip ? (joy_right & ~joy_left) : (joy_left & ~joy_right);
  assign y_pos = flip ? (joy_down & ~joy_up)    : (joy_up & ~joy_down);
  assign y_neg = flip ? (joy_up & ~joy_down)    : (joy_down & ~joy_up);

  ccastles_tb_axis #(
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_TICKS (ACCEL_TICKS)
  ) u_axis_x (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .dir_pos   (x_pos),
    .dir_neg   (x_neg),
    .mouse_vld (mouse_vld),
    .mouse_dat (mouse_dx),
    .mouse_inv (flip),
    .pos       (tbx),
    .active    (x_active)
  );

  ccastles_tb_axis #(
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_TICKS (ACCEL_TICKS)
  ) u_axis_y (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .dir_pos   (y_pos),
    .dir_neg   (y_neg),
    .mouse_vld (mouse_vld),
    .mouse_dat (mouse_dy),
    .mouse_inv (flip),
    .pos       (tby),
    .active    (y_active)
  );

  assign moving = x_active | y_active;

endmodule

// File: tb/tb_ccastles_trackball.sv
// Bench for ccastles_trackball: directed scenarios then random stimulus against a run-length reference model.
// Outputs are compared on every falling edge.
module tb_ccastles_trackball;

  localparam int TICK_DIV    = 4;
  localparam int MAX_SPEED   = 3;
  localparam int ACCEL_TICKS = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       joy_right, joy_left, joy_down, joy_up;
  logic [8:0] mouse_dx, mouse_dy;
  logic       mouse_strobe;
  logic       flip;
  logic [7:0] tbx, tby;
  logic       moving;

  int n_checks = 0;
  int n_fail   = 0;

  int ramp_exp [8] = '{1, 2, 4, 6, 9, 12, 15, 18};

  // Reference state: position, run length of the current held direction per axis.
  int   m_k, m_tbx, m_tby, m_run_x, m_run_y, m_last_x, m_last_y;
  bit   m_moving, m_ticked;
  logic m_prev_strobe;

  always #5 clk = ~clk;

  ccastles_trackball #(
    .TICK_DIV    (TICK_DIV),
    .MAX_SPEED   (MAX_SPEED),
    .ACCEL_TICKS (ACCEL_TICKS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .joy_right    (joy_right),
    .joy_left     (joy_left),
    .joy_down     (joy_down),
    .joy_up       (joy_up),
    .mouse_dx     (mouse_dx),
    .mouse_dy     (mouse_dy),
    .mouse_strobe (mouse_strobe),
    .flip         (flip),
    .tbx          (tbx),
    .tby          (tby),
    .moving       (moving)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap8(input int v);
    return ((v % 256) + 256) % 256;
  endfunction

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int speed_of(input int run);
    int s;
    s = 1 + (run - 1) / ACCEL_TICKS;
    return (s > MAX_SPEED) ? MAX_SPEED : s;
  endfunction

  task automatic model_reset();
    m_k = 0; m_tbx = 0; m_tby = 0;
    m_run_x = 0; m_run_y = 0; m_last_x = 0; m_last_y = 0;
    m_moving = 1'b0; m_ticked = 1'b0;
    m_prev_strobe = mouse_strobe;
  endtask

  task automatic axis_update(input int d, inout int run, inout int last, output int delta);
    if (d == 0) run = 0;
    else if (d == last && run > 0) run++;
    else run = 1;
    last  = d;
    delta = (d == 0) ? 0 : d * speed_of(run);
  endtask

  task automatic model_eval();
    int dx, dy;
    int jx = 0, jy = 0, mx = 0, my = 0;
    bit ev;
    m_ticked = ((m_k % TICK_DIV) == TICK_DIV - 1);
    ev = (m_k > 0) && (mouse_strobe !== m_prev_strobe);
    m_prev_strobe = mouse_strobe;
    if (m_ticked) begin
      dx = int'(joy_right) - int'(joy_left);
      dy = int'(joy_up) - int'(joy_down);
      if (flip) begin dx = -dx; dy = -dy; end
      axis_update(dx, m_run_x, m_last_x, jx);
      axis_update(dy, m_run_y, m_last_y, jy);
      m_moving = (m_run_x > 0) || (m_run_y > 0);
    end
    if (ev) begin
      mx = sat(int'($signed(mouse_dx)));
      my = sat(int'($signed(mouse_dy)));
      if (flip) begin mx = -mx; my = -my; end
    end
    m_tbx = wrap8(m_tbx + jx + mx);
    m_tby = wrap8(m_tby + jy + my);
    m_k++;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    @(negedge clk);
    chk("tbx", int'(tbx), m_tbx);
    chk("tby", int'(tby), m_tby);
    chk("moving", int'(moving), int'(m_moving));
  endtask

  task automatic run_to_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!m_ticked && n < 2 * TICK_DIV);
    if (!m_ticked) chk("tick_timeout", 0, 1);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) run_to_tick();
  endtask

  task automatic mouse_evt(input int dx, input int dy);
    mouse_dx = 9'(dx);
    mouse_dy = 9'(dy);
    mouse_strobe = ~mouse_strobe;
    step();
  endtask

  task automatic set_pos(input bit is_y, input int target);
    int need, d, guard;
    guard = 0;
    while ((is_y ? m_tby : m_tbx) != target && guard < 12) begin
      guard++;
      if ((m_k % TICK_DIV) == TICK_DIV - 1) begin
        step();
      end else begin
        need = wrap8(target - (is_y ? m_tby : m_tbx));
        if (need > 127) need -= 256;
        d = (need > 100) ? 100 : ((need < -100) ? -100 : need);
        if (flip) d = -d;
        if (is_y) mouse_evt(0, d);
        else mouse_evt(d, 0);
      end
    end
    chk(is_y ? "set_pos_y" : "set_pos_x", is_y ? int'(tby) : int'(tbx), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pre, pre_y;
    joy_right = 0; joy_left = 0; joy_down = 0; joy_up = 0;
    mouse_dx = '0; mouse_dy = '0; mouse_strobe = 1'b1; flip = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tbx", int'(tbx), 0);
    chk("rst_tby", int'(tby), 0);
    chk("rst_moving", int'(moving), 0);
    reset_n = 1'b1;
    model_reset();

    // Strobe high at release, nothing pressed: nothing may move.
    run_ticks(3);
    chk("idle_tbx", int'(tbx), 0);
    chk("idle_tby", int'(tby), 0);
    chk("idle_moving", int'(moving), 0);

    joy_right = 1;
    for (int i = 0; i < 8; i++) begin
      run_to_tick();
      chk("ramp_tbx", int'(tbx), ramp_exp[i]);
      chk("ramp_moving", int'(moving), 1);
    end
    joy_right = 0;
    run_to_tick();
    chk("release_moving", int'(moving), 0);
    chk("release_tbx", int'(tbx), 18);

    joy_right = 1;
    run_ticks(6);
    set_pos(0, 254);
    run_to_tick();
    chk("wrap_x", int'(tbx), 1);
    joy_right = 0;
    joy_down = 1;
    run_ticks(2);
    set_pos(1, 1);
    run_to_tick();
    chk("wrap_y", int'(tby), 255);
    joy_down = 0;
    run_to_tick();

    joy_right = 1;
    run_ticks(6);
    joy_right = 0;
    joy_left = 1;
    pre = m_tbx;
    run_to_tick();
    chk("rev_delta", int'(tbx), wrap8(pre - 1));
    chk("rev_moving", int'(moving), 1);
    run_to_tick();
    chk("rev_speed1", int'(tbx), wrap8(pre - 2));
    joy_left = 0;
    run_to_tick();

    pre = m_tbx;
    pre_y = m_tby;
    mouse_evt(200, -256);
    chk("mouse_sat_x", int'(tbx), wrap8(pre + 127));
    chk("mouse_sat_y", int'(tby), wrap8(pre_y - 127));

    joy_right = 1;
    run_ticks(2);
    step(); step(); step();
    pre = m_tbx;
    mouse_evt(127, 0);
    chk("coincide_x", int'(tbx), wrap8(pre + 129));
    joy_right = 0;
    run_to_tick();

    set_pos(0, 0);
    set_pos(1, 10);
    flip = 1'b1;
    joy_up = 1;
    run_to_tick();
    chk("flip_up", int'(tby), 9);
    joy_up = 0;
    run_to_tick();
    mouse_evt(5, 0);
    chk("flip_mouse", int'(tbx), 251);
    joy_left = 1;
    joy_right = 1;
    run_ticks(2);
    chk("both_x", int'(tbx), 251);
    chk("both_moving", int'(moving), 0);
    joy_left = 0;
    joy_right = 0;
    flip = 1'b0;

    // Reset asserted between clock edges must clear outputs without a clock.
    joy_right = 1;
    run_ticks(3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_tbx", int'(tbx), 0);
    chk("arst_tby", int'(tby), 0);
    chk("arst_moving", int'(moving), 0);
    joy_right = 0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) joy_right = ~joy_right;
      if ($urandom_range(0, 15) == 0) joy_left  = ~joy_left;
      if ($urandom_range(0, 15) == 0) joy_up    = ~joy_up;
      if ($urandom_range(0, 15) == 0) joy_down  = ~joy_down;
      if ($urandom_range(0, 63) == 0) flip      = ~flip;
      if ($urandom_range(0, 7) == 0) begin
        mouse_dx = 9'($urandom_range(0, 511));
        mouse_dy = 9'($urandom_range(0, 511));
        mouse_strobe = ~mouse_strobe;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
